// File: rtl/ap_ctrl_sequencer_if.sv
// ap_ctrl_hs handshake bundle between the sequencer (master) and an HLS core (slave).
interface ap_ctrl_sequencer_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;

    modport master (output ap_start, input ap_ready, input ap_done);
    modport slave  (input ap_start, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_sequencer.sv
// Drives an ap_ctrl_hs HLS core through a run of cfg_count invocations separated by
// cfg_gap idle cycles, with abort, watchdog, and per-run counters and latency stats.
module ap_ctrl_sequencer #(
    parameter int CNT_W = 16,
    parameter int LAT_W = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    ap_ctrl_sequencer_if.master   ap_if,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    input  logic                  cmd_clear,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic [7:0]            cfg_gap,
    input  logic [LAT_W-1:0]      cfg_timeout,
    output logic                  busy,
    output logic                  run_done,
    output logic                  aborted,
    output logic                  err,
    output logic [CNT_W-1:0]      issued_cnt,
    output logic [CNT_W-1:0]      done_cnt,
    output logic [LAT_W-1:0]      last_lat,
    output logic [LAT_W-1:0]      max_lat
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_GAP, S_ERR} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_cfg_count;
    logic [7:0]         r_cfg_gap;
    logic [LAT_W-1:0]   r_cfg_timeout;
    logic [LAT_W-1:0]   r_lat;
    logic [7:0]         r_gap_cnt;
    logic               r_abort_pend;
    logic               r_run_done;
    logic               r_aborted;
    logic               r_err;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_done;
    logic [LAT_W-1:0]   r_last_lat;
    logic [LAT_W-1:0]   r_max_lat;

    logic               w_start_run;
    logic               w_active;
    logic               w_ready_hit;
    logic               w_complete;
    logic               w_abort_now;
    logic [CNT_W-1:0]   w_done_inc;
    logic               w_run_end;
    logic               w_gap_skip;
    logic               w_timeout;
    logic [7:0]         w_gap_load;

    assign w_start_run = cmd_start && (cfg_count != '0);
    assign w_active    = (r_state == S_ISSUE) || (r_state == S_RUN);
    assign w_ready_hit = (r_state == S_ISSUE) && ap_if.ap_ready;
    assign w_complete  = ap_if.ap_done && (w_ready_hit || (r_state == S_RUN));
    assign w_abort_now = cmd_abort || r_abort_pend;
    assign w_done_inc  = r_done + 1'b1;
    assign w_run_end   = (w_done_inc == r_cfg_count) || w_abort_now;
    // ap_start must drop for at least one cycle after ap_ready, so a zero gap only
    // chains straight into ISSUE when the invocation finished in RUN.
    assign w_gap_skip  = (r_state == S_RUN) && (r_cfg_gap == 8'd0);
    assign w_gap_load  = (r_cfg_gap == 8'd0) ? 8'd1 : r_cfg_gap;
    assign w_timeout   = w_active && !w_complete && (r_cfg_timeout != '0)
                         && (r_lat >= r_cfg_timeout);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        ap_if.ap_start = 1'b0;
        busy           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) w_state_next = S_ISSUE;
            end
            S_ISSUE, S_RUN: begin
                ap_if.ap_start = (r_state == S_ISSUE);
                busy           = 1'b1;
                if (w_complete) begin
                    if (w_run_end)       w_state_next = S_IDLE;
                    else if (w_gap_skip) w_state_next = S_ISSUE;
                    else                 w_state_next = S_GAP;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else if (w_ready_hit) begin
                    w_state_next = S_RUN;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (cmd_abort)                w_state_next = S_IDLE;
                else if (r_gap_cnt == 8'd1)   w_state_next = S_ISSUE;
            end
            S_ERR: begin
                if (cmd_clear) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cfg_count   <= '0;
            r_cfg_gap     <= '0;
            r_cfg_timeout <= '0;
            r_lat         <= '0;
            r_gap_cnt     <= '0;
            r_abort_pend  <= 1'b0;
            r_run_done    <= 1'b0;
            r_aborted     <= 1'b0;
            r_err         <= 1'b0;
            r_issued      <= '0;
            r_done        <= '0;
            r_last_lat    <= '0;
            r_max_lat     <= '0;
        end else begin
            r_run_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_issued     <= '0;
                        r_done       <= '0;
                        r_last_lat   <= '0;
                        r_max_lat    <= '0;
                        r_aborted    <= 1'b0;
                        r_err        <= 1'b0;
                        r_abort_pend <= 1'b0;
                        if (w_start_run) begin
                            r_cfg_count   <= cfg_count;
                            r_cfg_gap     <= cfg_gap;
                            r_cfg_timeout <= cfg_timeout;
                            r_lat         <= {{(LAT_W-1){1'b0}}, 1'b1};
                        end else begin
                            r_run_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE, S_RUN: begin
                    if (cmd_abort)   r_abort_pend <= 1'b1;
                    if (w_ready_hit) r_issued     <= r_issued + 1'b1;
                    if (r_lat != {LAT_W{1'b1}}) r_lat <= r_lat + 1'b1;
                    if (w_complete) begin
                        r_done     <= w_done_inc;
                        r_last_lat <= r_lat;
                        if (r_lat > r_max_lat) r_max_lat <= r_lat;
                        if (w_run_end) begin
                            r_run_done   <= 1'b1;
                            r_aborted    <= w_abort_now;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_lat     <= {{(LAT_W-1){1'b0}}, 1'b1};
                            r_gap_cnt <= w_gap_load;
                        end
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (cmd_abort) begin
                        r_run_done   <= 1'b1;
                        r_aborted    <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end else if (r_gap_cnt == 8'd1) begin
                        r_lat <= {{(LAT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                S_ERR: begin
                    if (cmd_clear) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign run_done   = r_run_done;
    assign aborted    = r_aborted;
    assign err        = r_err;
    assign issued_cnt = r_issued;
    assign done_cnt   = r_done;
    assign last_lat   = r_last_lat;
    assign max_lat    = r_max_lat;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: a behavioural ap_ctrl_hs core, a run-result
// scoreboard popped on run_done, and per-step checks of handshake timing and status.
module tb_ap_ctrl_sequencer;
    logic        ap_clk;
    logic        ap_rst_n;
    logic        cmd_start, cmd_abort, cmd_clear;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [23:0] cfg_timeout;
    logic        busy, run_done, aborted, err;
    logic [15:0] issued_cnt, done_cnt;
    logic [23:0] last_lat, max_lat;

    ap_ctrl_sequencer_if ifc ();

    ap_ctrl_sequencer dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_if       (ifc),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .cmd_clear   (cmd_clear),
        .cfg_count   (cfg_count),
        .cfg_gap     (cfg_gap),
        .cfg_timeout (cfg_timeout),
        .busy        (busy),
        .run_done    (run_done),
        .aborted     (aborted),
        .err         (err),
        .issued_cnt  (issued_cnt),
        .done_cnt    (done_cnt),
        .last_lat    (last_lat),
        .max_lat     (max_lat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [15:0] done;
        logic [23:0] last;
        logic [23:0] maxl;
        logic        ab;
    } exp_t;
    exp_t sb_q[$];

    // Behavioural core: ready rdy_dly cycles into ap_start, done done_dly cycles in.
    int rdy_dly = 0, done_dly = 0, core_t = 0;
    bit never_done = 0, core_flush = 0, core_busy = 0, core_done_r = 0;
    always @(negedge ap_clk) begin
        if (!ap_rst_n || core_flush) begin
            core_busy   = 0;
            core_done_r = 0;
        end else if (core_done_r) begin
            core_busy   = 0;
            core_done_r = 0;
        end
        if (!core_busy && ap_rst_n && !core_flush && ifc.ap_start === 1'b1) begin
            core_busy = 1;
            core_t    = 0;
        end else if (core_busy) begin
            core_t++;
        end
        ifc.ap_ready = core_busy && (ifc.ap_start === 1'b1) && (core_t >= rdy_dly);
        ifc.ap_done  = core_busy && !never_done && (core_t == done_dly);
        core_done_r  = ifc.ap_done;
    end

    // Output monitor: ap_start edges, run_done pulses, scoreboard pops.
    int rise_cnt = 0, high_cnt = 0, rd_count = 0, rd_cyc = 0;
    int rise_q[$];
    logic prev_start = 1'b0;
    always @(negedge ap_clk) begin
        exp_t e;
        if (ifc.ap_start === 1'b1 && !prev_start) begin
            rise_cnt++;
            rise_q.push_back(cyc);
        end
        if (ifc.ap_start === 1'b1) high_cnt++;
        prev_start = (ifc.ap_start === 1'b1);
        if (run_done === 1'b1) begin
            rd_count++;
            rd_cyc = cyc;
            check("sb_expected_run", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_done_cnt", done_cnt, e.done);
                check("sb_last_lat", last_lat, e.last);
                check("sb_max_lat",  max_lat,  e.maxl);
                check("sb_aborted",  aborted,  e.ab);
                $display("run_done @%0d: done=%0d last=%0d max=%0d aborted=%0d",
                         cyc, done_cnt, last_lat, max_lat, aborted);
            end
        end
    end

    task automatic step();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
    endtask

    task automatic pulse_abort();
        cmd_abort = 1'b1; step(); cmd_abort = 1'b0;
    endtask

    task automatic wait_rd(input int n0, input int budget);
        for (int k = 0; k < budget && rd_count == n0; k++) step();
        check("run_done_seen", rd_count, n0 + 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int k = 0; k < budget && rise_cnt < target; k++) step();
        check("ap_start_rises_reached", 32'(rise_cnt >= target), 1);
    endtask

    task automatic set_cfg(input int cnt, input int gap, input int tmo);
        cfg_count   = 16'(cnt);
        cfg_gap     = 8'(gap);
        cfg_timeout = 24'(tmo);
    endtask

    task automatic set_core(input int r, input int d, input bit nd);
        rdy_dly = r; done_dly = d; never_done = nd;
    endtask

    initial begin
        int r0, d0, b0, h0, t0, tissue, terr;
        ap_rst_n = 1'b0;
        cmd_start = 1'b0; cmd_abort = 1'b0; cmd_clear = 1'b0;
        set_cfg(0, 0, 0);
        set_core(0, 0, 0);
        repeat (3) step();
        check("rst_ap_start", ifc.ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_err", err, 0);
        check("rst_issued", issued_cnt, 0);
        ap_rst_n = 1'b1;
        step();
        check("idle_after_release", busy, 0);

        // 3 invocations, gap 2, ready with start, done 3 cycles later
        set_cfg(3, 2, 0); set_core(0, 3, 0);
        sb_q.push_back('{done: 16'd3, last: 24'd4, maxl: 24'd4, ab: 1'b0});
        r0 = rise_cnt; d0 = rd_count; b0 = rise_q.size();
        pulse_start();
        wait_rd(d0, 100);
        repeat (5) step();
        check("t1_rises", rise_cnt - r0, 3);
        check("t1_spacing1", rise_q[b0+1] - rise_q[b0], 6);
        check("t1_spacing2", rise_q[b0+2] - rise_q[b0+1], 6);
        check("t1_issued", issued_cnt, 3);
        check("t1_one_run_done", rd_count - d0, 1);
        check("t1_busy_idle", busy, 0);
        $display("t1: rises=%0d issued=%0d done=%0d", rise_cnt - r0, issued_cnt, done_cnt);

        // core ready+done in first start cycle, 2 invocations, gap 0
        set_cfg(2, 0, 0); set_core(0, 0, 0);
        sb_q.push_back('{done: 16'd2, last: 24'd1, maxl: 24'd1, ab: 1'b0});
        r0 = rise_cnt; d0 = rd_count; b0 = rise_q.size(); h0 = high_cnt;
        pulse_start();
        wait_rd(d0, 50);
        repeat (3) step();
        check("t2_rises", rise_cnt - r0, 2);
        check("t2_high_cycles", high_cnt - h0, 2);
        check("t2_spacing", rise_q[b0+1] - rise_q[b0], 2);
        check("t2_one_run_done", rd_count - d0, 1);
        $display("t2: rises=%0d high=%0d", rise_cnt - r0, high_cnt - h0);

        // watchdog: timeout 10, core never done
        set_cfg(1, 0, 10); set_core(0, 0, 1);
        r0 = rise_cnt; d0 = rd_count; b0 = rise_q.size();
        pulse_start();
        wait_rises(r0 + 1, 20);
        tissue = rise_q[b0];
        terr = -1;
        for (int k = 0; k < 40 && terr < 0; k++) begin
            if (err === 1'b1) terr = cyc;
            else step();
        end
        check("t3_err_seen", err, 1);
        check("t3_err_delay", terr - tissue, 10);
        check("t3_ap_start_low", ifc.ap_start, 0);
        check("t3_busy", busy, 0);
        pulse_start();
        repeat (3) step();
        check("t3_start_ignored_err", err, 1);
        check("t3_frozen_issued", issued_cnt, 1);
        check("t3_no_run_done", rd_count - d0, 0);
        cmd_clear = 1'b1; core_flush = 1'b1; step(); cmd_clear = 1'b0; core_flush = 1'b0;
        step();
        check("t3_err_cleared", err, 0);
        check("t3_idle_busy", busy, 0);
        $display("t3: err delay=%0d", terr - tissue);

        // abort during RUN of 2nd invocation
        set_cfg(5, 1, 0); set_core(1, 4, 0);
        sb_q.push_back('{done: 16'd2, last: 24'd5, maxl: 24'd5, ab: 1'b1});
        r0 = rise_cnt; d0 = rd_count;
        pulse_start();
        wait_rises(r0 + 2, 50);
        repeat (2) step();
        pulse_abort();
        wait_rd(d0, 50);
        repeat (10) step();
        check("t4_no_third_start", rise_cnt - r0, 2);
        check("t4_aborted", aborted, 1);
        check("t4_one_run_done", rd_count - d0, 1);
        $display("t4: rises=%0d aborted=%0d", rise_cnt - r0, aborted);

        // abort during GAP
        set_cfg(5, 6, 0); set_core(0, 1, 0);
        sb_q.push_back('{done: 16'd1, last: 24'd2, maxl: 24'd2, ab: 1'b1});
        r0 = rise_cnt; d0 = rd_count;
        pulse_start();
        wait_rises(r0 + 1, 20);
        repeat (4) step();
        check("t5_in_gap", 32'({busy, ifc.ap_start}), 32'h2);
        t0 = cyc;
        pulse_abort();
        wait_rd(d0, 20);
        check("t5_rd_latency", rd_cyc - t0, 1);
        repeat (10) step();
        check("t5_no_more_starts", rise_cnt - r0, 1);
        $display("t5: rises=%0d rd_latency=%0d", rise_cnt - r0, rd_cyc - t0);

        // cfg_count = 0
        set_cfg(0, 0, 0);
        sb_q.push_back('{done: 16'd0, last: 24'd0, maxl: 24'd0, ab: 1'b0});
        r0 = rise_cnt; d0 = rd_count; t0 = cyc;
        pulse_start();
        wait_rd(d0, 10);
        check("t6_rd_latency", rd_cyc - t0, 1);
        check("t6_no_ap_start", rise_cnt - r0, 0);
        check("t6_issued_cleared", issued_cnt, 0);

        // cmd_start and cfg changes while busy have no effect
        set_cfg(3, 0, 0); set_core(0, 2, 0);
        sb_q.push_back('{done: 16'd3, last: 24'd3, maxl: 24'd3, ab: 1'b0});
        r0 = rise_cnt; d0 = rd_count;
        pulse_start();
        step();
        set_cfg(7, 9, 2);
        pulse_start();
        wait_rd(d0, 60);
        repeat (4) step();
        check("t7_rises", rise_cnt - r0, 3);
        check("t7_issued", issued_cnt, 3);
        check("t7_err", err, 0);
        $display("t7: rises=%0d issued=%0d", rise_cnt - r0, issued_cnt);

        // asynchronous reset mid-run, then a clean run
        set_cfg(4, 0, 0); set_core(0, 3, 0);
        r0 = rise_cnt; d0 = rd_count;
        pulse_start();
        wait_rises(r0 + 2, 40);
        step();
        check("t8_pre_busy", busy, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("t8_rst_ap_start", ifc.ap_start, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_issued", issued_cnt, 0);
        check("t8_rst_done", done_cnt, 0);
        check("t8_rst_last", last_lat, 0);
        check("t8_rst_max", max_lat, 0);
        repeat (3) step();
        ap_rst_n = 1'b1;
        step();
        check("t8_idle_after", busy, 0);
        check("t8_no_run_done", rd_count - d0, 0);
        set_cfg(2, 0, 0); set_core(0, 1, 0);
        sb_q.push_back('{done: 16'd2, last: 24'd2, maxl: 24'd2, ab: 1'b0});
        r0 = rise_cnt; d0 = rd_count;
        pulse_start();
        wait_rises(r0 + 1, 10);
        step();
        check("t8_issued_from_zero", issued_cnt, 1);
        wait_rd(d0, 40);
        check("t8_issued_final", issued_cnt, 2);
        $display("t8: post-reset issued=%0d done=%0d", issued_cnt, done_cnt);

        repeat (3) step();
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=%0d expected=finish", cyc);
        $fatal(1, "bench timed out");
    end
endmodule
